// File: rtl/mmio_responder.sv
// MMIO responder: control/status, down-counting timer, 4-deep byte FIFO,
// switch input and scratch registers on a shared tri-state bus; state moves on the falling CLK edge.
module mmio_responder #(
  parameter logic [6:0] BASE = 7'h70
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  wire  [31:0] Mem_Bus,
  output logic        io_sel,
  input  logic [7:0]  sw,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [3:0] OFF_CTRL    = 4'd0;
  localparam logic [3:0] OFF_STATUS  = 4'd1;
  localparam logic [3:0] OFF_LOAD    = 4'd2;
  localparam logic [3:0] OFF_COUNT   = 4'd3;
  localparam logic [3:0] OFF_TXDATA  = 4'd4;
  localparam logic [3:0] OFF_SWITCH  = 4'd5;
  localparam logic [3:0] OFF_SCRATCH = 4'd6;

  logic [3:0]  w_off;
  logic        w_wr;
  logic        w_rd_en;
  logic        w_ctrl_wr;
  logic        w_load_wr;
  logic        w_clr;
  logic        w_expire;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_drop;
  logic [31:0] w_rd_mux;

  logic        r_en;
  logic        r_ar;
  logic        r_ovf;
  logic        r_drop;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic [31:0] r_scratch;
  logic [31:0] r_rdata;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;
  logic [7:0]  r_fifo [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [2:0]  r_cnt;

  assign io_sel    = (ADDR[6:4] == BASE[6:4]);
  assign w_off     = ADDR[3:0];
  assign w_wr      = CS & WE & io_sel;
  assign w_rd_en   = CS & ~WE & io_sel;
  assign Mem_Bus   = w_rd_en ? r_rdata : 'z;

  assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);
  assign w_load_wr = w_wr && (w_off == OFF_LOAD);
  assign w_clr     = w_ctrl_wr & Mem_Bus[2];
  assign w_expire  = r_en && (r_count == 32'd0);

  assign out_valid = (r_cnt != 3'd0);
  assign out_data  = r_fifo[r_rp];
  assign w_full    = (r_cnt == 3'd4);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = w_wr && (w_off == OFF_TXDATA);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_off)
      OFF_CTRL:    w_rd_mux = {30'd0, r_ar, r_en};
      OFF_STATUS:  w_rd_mux = {25'd0, r_cnt, r_drop, r_ovf, w_full, ~out_valid};
      OFF_LOAD:    w_rd_mux = r_load;
      OFF_COUNT:   w_rd_mux = r_count;
      OFF_SWITCH:  w_rd_mux = {24'd0, r_sw_sync};
      OFF_SCRATCH: w_rd_mux = r_scratch;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge CLK) begin
    if (!RST) begin
      r_en      <= 1'b0;
      r_ar      <= 1'b0;
      r_ovf     <= 1'b0;
      r_drop    <= 1'b0;
      r_load    <= 32'd0;
      r_count   <= 32'd0;
      r_scratch <= 32'd0;
      r_rdata   <= 32'd0;
      r_sw_meta <= 8'd0;
      r_sw_sync <= 8'd0;
      r_wp      <= 2'd0;
      r_rp      <= 2'd0;
      r_cnt     <= 3'd0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_rdata   <= w_rd_mux;

      if (w_load_wr) r_load <= Mem_Bus;
      if (w_wr && (w_off == OFF_SCRATCH)) r_scratch <= Mem_Bus;

      if (w_load_wr)                        r_count <= Mem_Bus;
      else if (r_en && (r_count != 32'd0)) r_count <= r_count - 32'd1;
      else if (w_expire && r_ar)            r_count <= r_load;

      // An explicit CTRL write wins over the one-shot self-disable.
      if (w_ctrl_wr) begin
        r_en <= Mem_Bus[0];
        r_ar <= Mem_Bus[1];
      end else if (w_expire && !r_ar) begin
        r_en <= 1'b0;
      end

      if (w_expire)   r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;

      if (w_drop)     r_drop <= 1'b1;
      else if (w_clr) r_drop <= 1'b0;

      if (w_push_ok) r_wp <= r_wp + 2'd1;
      if (w_pop)     r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'd0, w_push_ok} - {2'd0, w_pop};
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(negedge CLK) begin
    if (RST && w_push_ok) r_fifo[r_wp] <= Mem_Bus[7:0];
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter BASE, default 7'h70: word address of register 0; the block decodes BASE..BASE+15.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the falling edge, matching system memory timing.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-low (0 = reset), sampled on the falling edge of CLK.
REQ-004 SHALL have port CS  input  1  bus chip select from the CPU.
REQ-005 SHALL have port WE  input  1  bus write enable from the CPU.
REQ-006 SHALL have port ADDR  input  7  bus word address.
REQ-007 SHALL have port Mem_Bus  inout  32  shared data bus.
REQ-008 SHALL have port io_sel  output  1  combinational, 1 when ADDR[6:4] == BASE[6:4]; the top level gates memory CS with it.
REQ-009 SHALL have port sw  input  8  external switch inputs.
REQ-010 SHALL have port out_data  output  8  FIFO head byte.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the head byte.

Function
REQ-013 Register map, offsets from BASE:
  0 CTRL: RW; bit0 = timer enable; bit1 = auto-reload; bit2 = write-1 clear of the sticky bits, self-clearing and reading 0.
  1 STATUS: RO; bit0 = empty, bit1 = full, bit2 = overflow sticky, bit3 = drop sticky, [6:4] = FIFO count.
  2 LOAD: RW, 32 bits.
  3 COUNT: RO, 32 bits.
  4 TXDATA: WO; Mem_Bus[7:0] is pushed into the FIFO.
  5 SWITCH: RO; {24'h0, sw_sync}.
  6 SCRATCH: RW, 32 bits.
  7-15: read 0; writes ignored.
REQ-014 Write: on a falling edge with CS=1, WE=1 and io_sel=1, the addressed register SHALL capture Mem_Bus.
REQ-015 Read: every falling edge SHALL capture the addressed register into rdata.
REQ-016 Mem_Bus SHALL be driven with rdata only while CS=1, WE=0 and io_sel=1; otherwise Mem_Bus SHALL be Z.
REQ-017 Read timing: data SHALL be valid before the next rising edge after CS is asserted, matching system memory.
REQ-018 Reads SHALL have no side effects.
REQ-019 sw SHALL pass through a 2-flop synchronizer; SWITCH reflects sw two falling edges after sw changes.
REQ-020 A write to LOAD SHALL also load COUNT with the same value on the same edge.
REQ-021 Timer: while enable=1 and COUNT!=0, COUNT SHALL decrement by 1 on each edge.
REQ-022 Timer expiry: on the edge where enable=1 and COUNT==0, the overflow sticky SHALL set.
  - auto-reload=1: COUNT reloads from LOAD on that edge.
  - auto-reload=0: COUNT holds 0 and enable clears on that edge.
REQ-023 A sticky-bit set SHALL take priority over a CTRL bit2 clear on the same edge.
REQ-024 A LOAD write SHALL take priority over decrement and reload on the same edge.
REQ-025 FIFO: 4 entries x 8 bits; circular read and write pointers wrap 3->0; count range 0..4.
REQ-026 out_valid SHALL equal (count != 0); out_data SHALL equal the head entry.
REQ-027 Pop: SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-028 Push into a full FIFO without a simultaneous pop SHALL be dropped, set the drop sticky, and leave contents unchanged.
REQ-029 Simultaneous push and pop SHALL both occur and leave count unchanged, including when full; push into an empty FIFO SHALL raise out_valid after that edge.
REQ-030 out_ready with an empty FIFO SHALL have no effect.

Reset
REQ-031 While RST=0 at a falling edge, the block SHALL clear CTRL, LOAD, COUNT, SCRATCH, rdata, both sticky bits, the FIFO pointers and count, and the synchronizer flops.
REQ-032 After reset, out_valid SHALL be 0 and Mem_Bus SHALL be Z.
REQ-033 Reset SHALL override any bus access or handshake on the same edge; FIFO contents are discarded.
REQ-034 io_sel SHALL remain combinational during reset.

Verification
REQ-035 SCRATCH round trip: write 32'hDEADBEEF to BASE+6, then read BASE+6 -> Mem_Bus = DEADBEEF during the read; Mem_Bus is Z when CS=0.
REQ-036 One-shot timer: write LOAD=3, then CTRL=1 -> COUNT reads 2,1,0 on successive edges; the overflow sticky sets on the 4th edge; then CTRL reads 0 and COUNT stays 0.
REQ-037 Auto-reload and clear: LOAD=1, CTRL=3 -> COUNT alternates 1,0,1,0 and overflow sets; write CTRL=4 on an expiry edge -> overflow stays 1; write CTRL=4 on a non-expiry edge -> overflow reads 0.
REQ-038 FIFO fill and drop, out_ready=0: push 11,22,33,44,55 -> STATUS = 0x4A (count 4, full, drop); out_data = 11.
REQ-039 FIFO drain: with the FIFO full, set out_ready=1 -> out_data sequence 11,22,33,44; then out_valid=0.
REQ-040 Push while full with out_ready=1 -> accepted, count stays 4.
REQ-041 Reset mid-operation: drive RST=0 one edge while the timer runs and the FIFO holds 2 entries -> next read of STATUS = 0x01 and COUNT = 0; out_valid=0.
